multiword_add_subt_ctrl: RTL and testbench

- Sequential controller that computes a (SW*NW)-bit add or subtract by time-multiplexing a single internal SW-bit ripple-carry Full_Adder_PG instance, one SW-bit word per cycle, LSW first.
- Carry is chained between words through a carry register.
- Sits in the FPU Add-Subt path. Used where wide mantissa/integer operations must reuse a narrow adder to save area.
- Start/Ready handshake toward the requesting control unit.

---
 rtl/multiword_add_subt_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multiword_add_subt_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multiword_add_subt_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | multiword_add_subt_ctrl: wide add/sub over one shared SW-bit adder     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+

module Full_Adder_PG #(
  parameter int SW = 26
) (
  input  logic [SW-1:0] Op_A_i,
  input  logic [SW-1:0] Op_B_i,
  input  logic          C_i,
  output logic [SW-1:0] S_o,
  output logic          C_o,
  output logic          P_o,
  output logic          G_o
);
  logic [SW-1:0] p;
  logic [SW-1:0] g;
  logic [SW:0]   c;
  logic [SW:0]   gg;

  assign c[0]  = C_i;
  assign gg[0] = 1'b0;

  // gg is the carry chain with zero carry-in, i.e. the group generate
  for (genvar i = 0; i < SW; i++) begin : g_bit
    assign p[i]    = Op_A_i[i] ^ Op_B_i[i];
    assign g[i]    = Op_A_i[i] & Op_B_i[i];
    assign S_o[i]  = p[i] ^ c[i];
    assign c[i+1]  = g[i] | (p[i] & c[i]);
    assign gg[i+1] = g[i] | (p[i] & gg[i]);
  end

  assign C_o = c[SW];
  assign P_o = &p;
  assign G_o = gg[SW];
endmodule

module multiword_add_subt_ctrl #(
  parameter int SW = 26,
  parameter int NW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start_i,
  input  logic             Op_i,
  input  logic [SW*NW-1:0] Op_A_i,
  input  logic [SW*NW-1:0] Op_B_i,
  output logic             Busy_o,
  output logic             Ready_o,
  output logic [SW*NW-1:0] Result_o,
  output logic             C_o,
  output logic             Zero_o,
  output logic             Ovf_o
);
  localparam int W  = SW * NW;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          sticky_q, sticky_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  beff_q, beff_d;
  logic [W-1:0]  result_q, result_d;
  logic          c_q, c_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;

  logic [SW-1:0] a_word;
  logic [SW-1:0] b_word;
  logic [SW-1:0] sum;
  logic          add_co;
  logic          unused_p;
  logic          unused_g;

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int k = 0; k < NW; k++) begin
      if (cnt_q == CW'(k)) begin
        a_word = op_a_q[k*SW +: SW];
        b_word = beff_q[k*SW +: SW];
      end
    end
  end

  Full_Adder_PG #(.SW(SW)) u_adder (
    .Op_A_i (a_word),
    .Op_B_i (b_word),
    .C_i    (carry_q),
    .S_o    (sum),
    .C_o    (add_co),
    .P_o    (unused_p),
    .G_o    (unused_g)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sticky_d = sticky_q;
    op_a_d   = op_a_q;
    beff_d   = beff_q;
    result_d = result_q;
    c_d      = c_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request so back-to-back operations lose no cycle
        if (Start_i) begin
          op_a_d   = Op_A_i;
          beff_d   = Op_B_i ^ {W{Op_i}};
          carry_d  = Op_i;
          cnt_d    = '0;
          sticky_d = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        for (int k = 0; k < NW; k++) begin
          if (cnt_q == CW'(k)) result_d[k*SW +: SW] = sum;
        end
        carry_d  = add_co;
        sticky_d = sticky_q & ~(|sum);
        if (cnt_q == CW'(NW - 1)) begin
          c_d     = add_co;
          ovf_d   = (a_word[SW-1] == b_word[SW-1]) && (sum[SW-1] != a_word[SW-1]);
          zero_d  = sticky_d;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sticky_q <= 1'b0;
      op_a_q   <= '0;
      beff_q   <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sticky_q <= sticky_d;
      op_a_q   <= op_a_d;
      beff_q   <= beff_d;
      result_q <= result_d;
      c_q      <= c_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Busy_o   = (state_q == RUN);
  assign Ready_o  = (state_q == DONE);
  assign Result_o = result_q;
  assign C_o      = c_q;
  assign Zero_o   = zero_q;
  assign Ovf_o    = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_multiword_add_subt_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_multiword_add_subt_ctrl: directed vectors for SW=8, NW=2            |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_multiword_add_subt_ctrl;
  localparam int SW = 8;
  localparam int NW = 2;
  localparam int W  = SW * NW;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start_i;
  logic         Op_i;
  logic [W-1:0] Op_A_i;
  logic [W-1:0] Op_B_i;
  logic         Busy_o;
  logic         Ready_o;
  logic [W-1:0] Result_o;
  logic         C_o;
  logic         Zero_o;
  logic         Ovf_o;

  int checks = 0;
  int errors = 0;

  multiword_add_subt_ctrl #(.SW(SW), .NW(NW)) dut (
    .clk      (clk),
    .rst      (rst),
    .Start_i  (Start_i),
    .Op_i     (Op_i),
    .Op_A_i   (Op_A_i),
    .Op_B_i   (Op_B_i),
    .Busy_o   (Busy_o),
    .Ready_o  (Ready_o),
    .Result_o (Result_o),
    .C_o      (C_o),
    .Zero_o   (Zero_o),
    .Ovf_o    (Ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] res, input logic c,
                            input logic z, input logic v);
    chk({tag, " result"}, 32'(Result_o), 32'(res));
    chk({tag, " C_o"},    32'(C_o),      32'(c));
    chk({tag, " Zero_o"}, 32'(Zero_o),   32'(z));
    chk({tag, " Ovf_o"},  32'(Ovf_o),    32'(v));
  endtask

  // Issue one operation from a negedge and wait (bounded) for Ready_o
  task automatic run_op(input string tag, input vec_t v);
    int n;
    int busy_cnt;
    @(negedge clk);
    Start_i = 1'b1; Op_i = v.op; Op_A_i = v.a; Op_B_i = v.b;
    @(negedge clk);
    Start_i = 1'b0;
    n = 0; busy_cnt = 0;
    while (!Ready_o && n < 20) begin
      if (Busy_o) busy_cnt++;
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(NW));
    chk({tag, " ready latency"}, 32'(n), 32'(NW));
    check_outs(tag, v.res, v.c, v.z, v.v);
    @(negedge clk);
    chk({tag, " ready pulse width"}, 32'(Ready_o), 32'(0));
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; Start_i = 1'b0; Op_i = 1'b0; Op_A_i = '0; Op_B_i = '0;
    @(negedge clk);
    chk("reset busy",  32'(Busy_o),  32'(0));
    chk("reset ready", 32'(Ready_o), 32'(0));
    check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Start held high, operands changed mid-RUN, then accepted again in DONE
    @(negedge clk);
    Start_i = 1'b1; Op_i = 1'b0; Op_A_i = 16'h0001; Op_B_i = 16'h0001;
    @(negedge clk);
    chk("b2b busy1", 32'(Busy_o), 32'(1));
    Op_A_i = 16'h1111; Op_B_i = 16'h1111;
    @(negedge clk);
    chk("b2b busy2", 32'(Busy_o), 32'(1));
    @(negedge clk);
    chk("b2b ready1", 32'(Ready_o), 32'(1));
    check_outs("b2b first", 16'h0002, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    Start_i = 1'b0;
    chk("b2b rerun busy", 32'(Busy_o), 32'(1));
    @(negedge clk);
    chk("b2b rerun busy2", 32'(Busy_o), 32'(1));
    @(negedge clk);
    chk("b2b ready2", 32'(Ready_o), 32'(1));
    check_outs("b2b second", 16'h2222, 1'b0, 1'b0, 1'b0);

    // Asynchronous abort during the first RUN cycle
    @(negedge clk);
    Start_i = 1'b1; Op_i = 1'b0; Op_A_i = 16'h7FFF; Op_B_i = 16'h0001;
    @(negedge clk);
    Start_i = 1'b0;
    chk("abort busy before rst", 32'(Busy_o), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("abort busy",  32'(Busy_o),  32'(0));
    chk("abort ready", 32'(Ready_o), 32'(0));
    check_outs("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no ready", 32'(Ready_o), 32'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-abort idle ready", 32'(Ready_o), 32'(0));
    end
    run_op("after abort", vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
